// File: rtl/sw_pwm_pkg.sv
// sw_pwm_pkg: mode-state encoding and parameter defaults shared by the sw_pwm_gen slice
package sw_pwm_pkg;
  typedef enum logic [1:0] {MANUAL, RAMP_UP, RAMP_DOWN} mode_t;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_SW_W = 4;
  localparam int DEF_DIV = 1;
  localparam int DEF_RAMP_PERIODS = 1;
endpackage

// File: rtl/sw_pwm_chan.sv
// sw_pwm_chan: per-channel manual duty, boundary-latched effective duty and PWM comparator
module sw_pwm_chan
  import sw_pwm_pkg::*;
#(
  parameter int SW_W = DEF_SW_W
)(
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            wr_en,
  input  logic            use_ramp,
  input  logic [SW_W-1:0] sw,
  input  logic [SW_W-1:0] ramp,
  input  logic [SW_W-1:0] cnt,
  output logic            out
);
  logic [SW_W-1:0] man_duty, eff_duty;
  // eff_duty reads the pre-write man_duty, so a same-cycle write lands one period later
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      man_duty <= '0;
      eff_duty <= '0;
      out <= 1'b0;
    end else begin
      if (wr_en) man_duty <= sw;
      if (load) eff_duty <= use_ramp ? ramp : man_duty;
      out <= cnt < eff_duty;
    end
endmodule

// File: rtl/sw_pwm_gen.sv
// sw_pwm_gen: switch-loaded multi-channel PWM with triangle auto-ramp;
// define SW_PWM_GEN_SYNC_EN to add two-flop synchronizers on sw/chan_sel/write/auto
module sw_pwm_gen
  import sw_pwm_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SW_W = DEF_SW_W,
  parameter int DIV = DEF_DIV,
  parameter int RAMP_PERIODS = DEF_RAMP_PERIODS,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
)(
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic [SW_W-1:0]     sw,
  input  logic [CW-1:0]       chan_sel,
  input  logic                write,
  input  logic                auto,
  output logic [CHANNELS-1:0] out,
  output logic                auto_active
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [SW_W-1:0] TOP = SW_W'((1 << SW_W) - 2);
  localparam logic [SW_W-1:0] FULL = '1;
  logic [SW_W-1:0] sw_s;
  logic [CW-1:0] sel_s;
  logic wr_s, auto_s;
`ifdef SW_PWM_GEN_SYNC_EN
  logic [SW_W+CW+1:0] s1, s2;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {sw, chan_sel, write, auto};
      s2 <= s1;
    end
  assign {sw_s, sel_s, wr_s, auto_s} = s2;
`else
  assign {sw_s, sel_s, wr_s, auto_s} = {sw, chan_sel, write, auto};
`endif
  logic [DW-1:0] div;
  logic [SW_W-1:0] cnt, ramp, ramp_nx;
  logic [7:0] rp;
  logic tick, bnd, rise, rp_last, wr_d;
  mode_t mode;
  assign tick = div == DW'(DIV - 1);
  assign bnd = tick && cnt == TOP;
  assign rise = wr_s && !wr_d;
  assign rp_last = rp == 8'(RAMP_PERIODS - 1);
  always_comb
    ramp_nx = mode == MANUAL ? '0 : !rp_last ? ramp : mode == RAMP_UP ? ramp + 1'b1 : ramp - 1'b1;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      cnt <= '0;
      wr_d <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      cnt <= !tick ? cnt : bnd ? '0 : cnt + 1'b1;
      wr_d <= wr_s;
    end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      mode <= MANUAL;
      ramp <= '0;
      rp <= '0;
      auto_active <= 1'b0;
    end else if (bnd) begin
      if (!auto_s) begin
        mode <= MANUAL;
        ramp <= '0;
        rp <= '0;
        auto_active <= 1'b0;
      end else begin
        ramp <= ramp_nx;
        rp <= (mode == MANUAL || rp_last) ? '0 : rp + 1'b1;
        auto_active <= 1'b1;
        mode <= mode == MANUAL ? RAMP_UP : ramp_nx == FULL ? RAMP_DOWN : ramp_nx == '0 ? RAMP_UP : mode;
      end
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sw_pwm_chan #(.SW_W(SW_W)) u_ch (
      .sysclk(sysclk),
      .rst_n(rst_n),
      .load(bnd),
      .wr_en(rise && sel_s == CW'(i)),
      .use_ramp(auto_s),
      .sw(sw_s),
      .ramp(ramp_nx),
      .cnt(cnt),
      .out(out[i])
    );
  end
endmodule

// File: tb/tb_sw_pwm_gen.sv
// tb_sw_pwm_gen: directed + randomized checks of sw_pwm_gen against a behavioural period model
module tb_sw_pwm_gen;
  logic sysclk = 1'b0, rst_n = 1'b1, write = 1'b0, auto = 1'b0;
  logic [3:0] sw = '0;
  logic [0:0] chan_sel = '0;
  logic [1:0] sel3 = 2'd3;
  logic [1:0] out;
  logic [2:0] out3;
  logic act, act3;
  int n_chk = 0, n_pass = 0;
  int m_cnt, m_ramp, m_dir, m_eff3;
  int m_man[2], m_eff[2];
  bit m_act, m_wprev;
  logic [1:0] m_out;
  logic [2:0] m_out3;
  int h0, h1;

  always #10 sysclk = ~sysclk;

  sw_pwm_gen dut (.sysclk(sysclk), .rst_n(rst_n), .sw(sw), .chan_sel(chan_sel), .write(write),
                  .auto(auto), .out(out), .auto_active(act));
  sw_pwm_gen #(.CHANNELS(3)) dut3 (.sysclk(sysclk), .rst_n(rst_n), .sw(sw), .chan_sel(sel3),
                  .write(write), .auto(auto), .out(out3), .auto_active(act3));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int tri_d(int k);
    int p = k % 30;
    return p <= 15 ? p : 30 - p;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ramp = 0; m_dir = 0; m_eff3 = 0; m_act = 0; m_wprev = 0;
    m_man = '{0, 0}; m_eff = '{0, 0}; m_out = '0; m_out3 = '0;
  endtask

  // one sysclk of the rules: duty compare, boundary reload/ramp, write edge, counter
  task automatic model_step();
    for (int i = 0; i < 2; i++) m_out[i] = m_cnt < m_eff[i];
    m_out3 = {3{m_cnt < m_eff3}};
    if (m_cnt == 14) begin
      if (!auto) begin
        m_eff = m_man; m_eff3 = 0; m_dir = 0; m_act = 0;
      end else begin
        if (m_dir == 0) begin m_ramp = 0; m_dir = 1; end
        else begin
          m_ramp += m_dir;
          if (m_ramp == 15) m_dir = -1;
          else if (m_ramp == 0) m_dir = 1;
        end
        m_eff = '{m_ramp, m_ramp}; m_eff3 = m_ramp; m_act = 1;
      end
    end
    if (write && !m_wprev) m_man[chan_sel] = sw;
    m_wprev = write;
    m_cnt = (m_cnt + 1) % 15;
  endtask

  task automatic step();
    @(posedge sysclk);
    model_step();
    #1;
    chk("out", out, m_out);
    chk("auto_active", act, m_act);
    chk("out3", out3, m_out3);
    chk("auto_active3", act3, m_act);
  endtask

  task automatic align();
    do step(); while (m_cnt != 0);
  endtask

  task automatic period(output int c0, output int c1);
    c0 = 0; c1 = 0;
    repeat (15) begin
      step();
      c0 += int'(out[0]);
      c1 += int'(out[1]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_act", act, 0);
    chk("rst_out3", out3, 0);
    model_reset();
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5;
    do_reset();
    repeat (3) step();
    // load full duty on ch0
    sw = 4'hF; chan_sel = 1'b0; write = 1'b1;
    step();
    write = 1'b0;
    align();
    period(h0, h1);
    chk("r33_hi0", h0, 15);
    chk("r33_hi1", h1, 0);
    // held-high write loads only the value present at the rising edge
    sw = 4'd5; chan_sel = 1'b1; write = 1'b1;
    step();
    sw = 4'd9;
    repeat (99) step();
    write = 1'b0;
    align();
    period(h0, h1);
    chk("r34_hi1", h1, 5);
    chk("r34_hi0", h0, 15);
    repeat (20) begin
      sw = 4'($urandom_range(0, 15));
      chan_sel = 1'($urandom_range(0, 1));
      write = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      write = 1'b0;
      repeat ($urandom_range(1, 20)) step();
    end
    // auto ramp
    align();
    auto = 1'b1;
    period(h0, h1);
    for (int k = 0; k < 40; k++) begin
      period(h0, h1);
      chk("r35_duty", h0, tri_d(k));
      chk("r35_act", act, 1);
    end
    sw = 4'd3; chan_sel = 1'b0; write = 1'b1;
    step();
    write = 1'b0;
    align();
    period(h0, h1);
    chk("r36_ramp", h0, tri_d(41));
    auto = 1'b0;
    period(h0, h1);
    period(h0, h1);
    chk("r36_hi0", h0, 3);
    chk("r36_act", act, 0);
    // reset mid-ramp
    auto = 1'b1;
    repeat (107) step();
    auto = 1'b0;
    do_reset();
    align();
    period(h0, h1);
    chk("r37_hi0", h0, 0);
    chk("r37_hi1", h1, 0);
    chk("r37_act", act, 0);
    // out-of-range channel on the 3-channel instance
    sw = 4'hF; write = 1'b1;
    step();
    write = 1'b0;
    align();
    period(h0, h1);
    chk("r38_out3", out3, 0);
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
